// File: rtl/ariane_pkg.sv
// Shared frontend types for the branch history table.
// Carries the resolve-report and prediction structs plus the 2-bit
// saturating counter helper used by bht_update_unit.
package ariane_pkg;

    localparam int unsigned BHT_NR_ENTRIES = 1024;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // Next value of a 2-bit saturating counter after one outcome.
    function automatic logic [1:0] sat_cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) nxt = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_update_unit.sv
// Branch history table: per-entry 2-bit saturating counters trained from
// resolved conditional branches, with a same-cycle lookup for the fetch PC.
// Updates are registered for one cycle before the table write, so a report
// in cycle N is visible to lookups from cycle N+2 (no bypass).
// Optional macro BHT_GSHARE_EN: XOR the index with a global history register.
module bht_update_unit
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BHT_NR_ENTRIES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [63:0]     vpc_i,
    input  bp_resolve_t     resolved_branch_i,
    output bht_prediction_t bht_prediction_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    logic             valid_q [NR_ENTRIES];
    logic [1:0]       cnt_q   [NR_ENTRIES];

    logic             update_valid_q;
    logic [IDX_W-1:0] update_idx_q;
    logic             update_taken_q;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] capture_idx;
    logic             capture_en;

    assign capture_en = resolved_branch_i.valid
                      && (resolved_branch_i.cf_type == Branch)
                      && !debug_mode_i
                      && !flush_i;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign lookup_idx  = vpc_i[IDX_W:1] ^ ghr_q;
    assign capture_idx = resolved_branch_i.pc[IDX_W:1] ^ ghr_q;

    // Global history: shift in each captured outcome; cleared with the table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else if (flush_i) begin
            ghr_q <= '0;
        end else if (capture_en) begin
            ghr_q <= {ghr_q[IDX_W-2:0], resolved_branch_i.is_taken};
        end
    end
`else
    assign lookup_idx  = vpc_i[IDX_W:1];
    assign capture_idx = resolved_branch_i.pc[IDX_W:1];
`endif

    // Fetch-side lookup, purely combinational.
    always_comb begin
        bht_prediction_o.valid = valid_q[lookup_idx];
        bht_prediction_o.taken = cnt_q[lookup_idx][1];
    end

    // Register qualifying conditional-branch reports for next-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_valid_q <= 1'b0;
            update_idx_q   <= '0;
            update_taken_q <= 1'b0;
        end else begin
            update_valid_q <= capture_en;
            if (capture_en) begin
                update_idx_q   <= capture_idx;
                update_taken_q <= resolved_branch_i.is_taken;
            end
        end
    end

    // Table write: first touch installs a weak counter, later updates saturate.
    // Flush wins over a pending write so the cleared table stays clean.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '{default: 1'b0};
            cnt_q   <= '{default: 2'b00};
        end else if (flush_i) begin
            valid_q <= '{default: 1'b0};
            cnt_q   <= '{default: 2'b00};
        end else if (update_valid_q) begin
            if (!valid_q[update_idx_q]) begin
                valid_q[update_idx_q] <= 1'b1;
                cnt_q[update_idx_q]   <= update_taken_q ? 2'b10 : 2'b01;
            end else begin
                cnt_q[update_idx_q]   <= sat_cnt_update(cnt_q[update_idx_q], update_taken_q);
            end
        end
    end

    // Report fields and PC bits that never reach the index.
    logic unused_bits;
    assign unused_bits = ^{resolved_branch_i.target_address,
                           resolved_branch_i.is_mispredict,
                           resolved_branch_i.pc[63:IDX_W+1],
                           resolved_branch_i.pc[0],
                           vpc_i[63:IDX_W+1],
                           vpc_i[0]};

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed bench for bht_update_unit (default PC-indexed build).
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_bht_update_unit;
    import ariane_pkg::*;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_i;
    logic            debug_mode_i;
    logic [63:0]     vpc_i;
    bp_resolve_t     resolved_branch_i;
    bht_prediction_t bht_prediction_o;

    int n_assert = 0;
    int n_fail   = 0;

    bht_update_unit #(.NR_ENTRIES(1024)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .debug_mode_i     (debug_mode_i),
        .vpc_i            (vpc_i),
        .resolved_branch_i(resolved_branch_i),
        .bht_prediction_o (bht_prediction_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Look up a PC and compare {valid, taken}.
    task automatic lookup(input string tag, input logic [63:0] pc, input logic [1:0] exp);
        logic [1:0] obs;
        vpc_i = pc;
        #1;
        obs = bht_prediction_o;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {valid,taken}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Present one resolve report for exactly one rising edge. Call at a falling edge.
    task automatic send(input logic [63:0] pc, input logic taken, input cf_t cf,
                        input logic v, input logic dbg);
        bp_resolve_t rb;
        rb                = '0;
        rb.valid          = v;
        rb.pc             = pc;
        rb.target_address = pc + 64'h40;
        rb.is_mispredict  = 1'b1;
        rb.is_taken       = taken;
        rb.cf_type        = cf;
        resolved_branch_i = rb;
        debug_mode_i      = dbg;
        @(negedge clk_i);
        resolved_branch_i.valid = 1'b0;
        debug_mode_i            = 1'b0;
    endtask

    task automatic br(input logic [63:0] pc, input logic taken);
        send(pc, taken, Branch, 1'b1, 1'b0);
    endtask

    localparam logic [63:0] PC8   = 64'h8000_0010;
    localparam logic [63:0] PC8A  = 64'h8000_0810;
    localparam logic [63:0] PC9   = 64'h8000_0012;

    initial begin
        rst_ni            = 1'b0;
        flush_i           = 1'b0;
        debug_mode_i      = 1'b0;
        vpc_i             = 64'h8000_0000;
        resolved_branch_i = '0;

        // Reset
        lookup("in_reset", 64'h8000_0000, 2'b00);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        lookup("after_reset", 64'h8000_0000, 2'b00);

        // Filtering: none of these may touch index 8
        send(PC8, 1'b1, JumpR, 1'b1, 1'b0);
        @(negedge clk_i);
        lookup("filt_jumpr", PC8, 2'b00);
        send(PC8, 1'b1, Branch, 1'b1, 1'b1);
        @(negedge clk_i);
        lookup("filt_debug", PC8, 2'b00);
        send(PC8, 1'b1, Branch, 1'b0, 1'b0);
        @(negedge clk_i);
        lookup("filt_invalid", PC8, 2'b00);

        // Training: first taken installs weak-taken, visible at N+2 only
        br(PC8, 1'b1);
        lookup("pre_write_n1", PC8, 2'b00);
        @(negedge clk_i);
        lookup("train_cnt2", PC8, 2'b11);
        br(PC8, 1'b1);  @(negedge clk_i);
        lookup("train_cnt3", PC8, 2'b11);
        br(PC8, 1'b0);  @(negedge clk_i);
        lookup("nt_cnt2", PC8, 2'b11);
        br(PC8, 1'b0);  @(negedge clk_i);
        lookup("nt_cnt1", PC8, 2'b10);
        br(PC8, 1'b0);  @(negedge clk_i);
        lookup("nt_cnt0", PC8, 2'b10);
        br(PC8, 1'b0);  @(negedge clk_i);
        lookup("nt_sat0", PC8, 2'b10);
        // from 0 one taken gives 1 (not-taken); a wrapped counter would read taken
        br(PC8, 1'b1);  @(negedge clk_i);
        lookup("sat0_then_t", PC8, 2'b10);

        // Back-to-back updates, each seeing the previous write: 1 -> 2 -> 3
        br(PC8, 1'b1);
        br(PC8, 1'b1);
        @(negedge clk_i);
        lookup("b2b_t_cnt3", PC8, 2'b11);
        // 3 -> 2 -> 1
        br(PC8, 1'b0);
        br(PC8, 1'b0);
        @(negedge clk_i);
        lookup("b2b_nt_cnt1", PC8, 2'b10);

        // Aliasing: 1 -> 2
        br(PC8, 1'b1);  @(negedge clk_i);
        lookup("alias_same_idx", PC8A, 2'b11);
        lookup("alias_idx9",     PC9,  2'b00);

        // Flush with a concurrent update on index 9: 2 -> 3 first
        br(PC8, 1'b1);  @(negedge clk_i);
        lookup("pre_flush_idx8", PC8, 2'b11);
        flush_i = 1'b1;
        br(PC9, 1'b1);
        flush_i = 1'b0;
        lookup("flush_idx8", PC8, 2'b00);
        lookup("flush_idx9", PC9, 2'b00);
        @(negedge clk_i);
        lookup("flush_drop_idx9", PC9, 2'b00);

        // Asynchronous reset mid-operation
        br(PC8, 1'b1);  @(negedge clk_i);
        lookup("retrain_idx8", PC8, 2'b11);
        br(PC9, 1'b1);          // now in flight in the update register
        #2 rst_ni = 1'b0;
        lookup("async_rst_idx8", PC8, 2'b00);
`ifdef BHT_GSHARE_EN
        n_assert++;
        assert (dut.ghr_q === '0) else begin
            n_fail++;
            $error("FAIL ghr_reset: observed %h expected 0", dut.ghr_q);
        end
`endif
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        lookup("inflight_lost_idx9", PC9, 2'b00);
        br(PC9, 1'b0);  @(negedge clk_i);
        lookup("post_rst_weak_nt", PC9, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bht_update_unit.md
Name: bht_update_unit

Overview:
- Branch history table (BHT) in the frontend; consumes resolved-branch reports from the execute-stage branch unit.
- Trains per-entry 2-bit saturating counters from resolved conditional branches.
- Answers same-cycle taken/not-taken lookups for the fetch PC.
- Write side sits at the end of the resolve path, after the branch unit.

Parameters:
NR_ENTRIES, 1024, number of table entries; power of two, >= 4
IDX_W, $clog2(NR_ENTRIES), index width (localparam, derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  clear entire table (e.g. fence.i / context switch)
debug_mode_i  in  1  core in debug mode; training suppressed
vpc_i  in  64  fetch PC to predict
resolved_branch_i  in  ariane_pkg::bp_resolve_t  resolve report from branch unit (valid, pc, target_address, is_mispredict, is_taken, cf_type)
bht_prediction_o  out  ariane_pkg::bht_prediction_t  {valid, taken} for vpc_i

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_ni is asynchronous, active-low. While it is low, all entries are {valid=0, cnt=2'b00} and update_q.valid=0.
  - bht_prediction_o therefore reads {0,0} during and after reset until training occurs.
- Index:
  - idx(pc) = pc[IDX_W:1]. Bit 0 is ignored because of 2-byte alignment; bits above IDX_W are ignored, so aliasing is allowed.
- Lookup (combinational, 0 cycles):
  - bht_prediction_o.valid = entry[idx(vpc_i)].valid.
  - bht_prediction_o.taken = entry[idx(vpc_i)].cnt[1].
- Update capture (cycle N):
  - Condition: resolved_branch_i.valid && cf_type==Branch && !debug_mode_i && !flush_i.
  - On the condition, register {idx(pc), is_taken} into update_q and set update_q.valid=1; otherwise update_q.valid=0.
  - Other cf_types (JumpR, Return, Jump, NoCF) are ignored, including mispredicts.
- Table write (cycle N+1), when update_q.valid:
  - Entry invalid: set valid=1; cnt = taken ? 2'b10 : 2'b01 (weak).
  - Entry valid, taken: cnt = (cnt==3) ? 3 : cnt+1.
  - Entry valid, not taken: cnt = (cnt==0) ? 0 : cnt-1.
- Visibility:
  - An update presented in cycle N is visible on the lookup port from cycle N+2.
  - A lookup of the entry being written in N+1 returns the pre-write value. No bypass.
- Back-to-back:
  - One update per cycle is accepted with no stall.
  - Consecutive updates to the same index each apply in order, each seeing the previous write.
- Flush:
  - flush_i=1 at an edge clears every entry's valid and cnt, and drops update_q (no write).
  - An update presented in the same cycle as flush_i is discarded.
  - The table is cleared in a single cycle.
- No handshakes: the block never backpressures the branch unit.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined (gshare indexing):
  - Adds ghr_q[IDX_W-1:0], reset and flush value 0.
  - Lookup index = idx(vpc_i) ^ ghr_q.
  - Capture stores idx(pc) ^ ghr_q, using ghr_q before the shift.
  - ghr_q <= {ghr_q[IDX_W-2:0], is_taken} on each captured update.
- Undefined: plain PC indexing as above; ghr_q does not exist.

Decomposition:
- Add to ariane_pkg:
  - bht_prediction_t {logic valid; logic taken;}.
  - Localparam BHT_NR_ENTRIES = 1024.
  - Function sat_cnt_update(cnt, taken) returning the next 2-bit count.
- No sub-module. Table is a flop array in this module (120-250 lines total).

Test Plan:
- Reset: rst_ni low 3 cycles, then vpc_i=0x8000_0000 -> bht_prediction_o={0,0}.
- Training and saturation: valid Branch report, pc=0x8000_0010, taken=1, at cycle 0.
  - Cycle 2, vpc_i=0x8000_0010 -> {1,1} (cnt=2).
  - Second taken -> cnt=3.
  - Three not-taken -> cnt 2,1,0; last taken=0.
  - Fourth not-taken -> cnt stays 0.
- Aliasing: train pc=0x8000_0010 taken -> vpc_i=0x8000_0810 (same index 8) reads {1,1}; vpc_i=0x8000_0012 (index 9) reads {0,0}.
- Filtering, each case leaves index 8 invalid:
  - cf_type=JumpR, valid=1.
  - cf_type=Branch with debug_mode_i=1.
  - cf_type=Branch with valid=0.
- Flush: train index 8 to cnt=3, then flush_i=1 concurrent with a new Branch update on index 9 -> next cycle both index 8 and 9 read {0,0}.
- Async reset mid-operation: after training, drop rst_ni between clock edges -> prediction for trained PC goes {0,0} without a clock edge; in-flight update_q is lost. With BHT_GSHARE_EN, additionally check ghr_q=0 after reset.
